// File: rtl/random_checker.sv
// ----------------------------------------------------------------------------
// random_checker
//
// Receive end of the 10-bit LFSR random bit stream (x^10 + x^7 + 1, period
// 1023). The serial input is sampled once per bit_en strobe. The checker
// fills a 10-bit history, then verifies that the stream obeys the sequence
// law b[n] = b[n-10] ^ b[n-7]. After LOCK_CNT consecutive correct
// predictions it locks. While locked, it runs a local copy of the generator
// and counts real bit errors. LOSS_CNT consecutive mismatches drop the lock.
//
// Ports
//   clk        in   1      system clock, all logic on posedge
//   rst_n      in   1      asynchronous reset, active-low
//   bit_en     in   1      sample strobe, din is valid only while high
//   din        in   1      serial random bit under test
//   clear      in   1      synchronous: zero err_count and restart in FILL
//   locked     out  1      registered, high while the FSM is in LOCKED
//   err_pulse  out  1      registered, one clk wide per counted bit error
//   err_count  out  ERR_W  saturating count of bit errors while locked
// ----------------------------------------------------------------------------
module random_checker #(
    parameter int LOCK_CNT = 20,
    parameter int LOSS_CNT = 4,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_en,
    input  logic             din,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [7:0]       LOCK_C  = 8'(LOCK_CNT);
    localparam logic [7:0]       LOSS_C  = 8'(LOSS_CNT);
    localparam logic [ERR_W-1:0] CNT_MAX = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] CNT_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

    // Next bit predicted from the history, hist[0] being the newest bit.
    function automatic logic lfsr_pred(input logic [9:0] h);
        return h[9] ^ h[6];
    endfunction

    state_t           state_r, state_s;
    logic [9:0]       hist_r, hist_s;
    logic [3:0]       fill_r, fill_s;
    logic [7:0]       match_r, match_s;
    logic [7:0]       miss_r, miss_s;
    logic             locked_r, locked_s;
    logic             pulse_r, pulse_s;
    logic [ERR_W-1:0] cnt_r, cnt_s;
    logic             pred_s;
    logic             hit_s;

    assign pred_s    = lfsr_pred(hist_r);
    assign hit_s     = (din == pred_s);
    assign locked    = locked_r;
    assign err_pulse = pulse_r;
    assign err_count = cnt_r;

    // Next-state and next-output logic: clear wins over bit_en, idle clocks hold.
    always_comb begin
        state_s = state_r;
        hist_s  = hist_r;
        fill_s  = fill_r;
        match_s = match_r;
        miss_s  = miss_r;
        pulse_s = 1'b0;
        cnt_s   = cnt_r;
        if (clear) begin
            state_s = ST_FILL;
            hist_s  = 10'd0;
            fill_s  = 4'd0;
            match_s = 8'd0;
            miss_s  = 8'd0;
            cnt_s   = {ERR_W{1'b0}};
        end else if (bit_en) begin
            case (state_r)
                ST_FILL: begin
                    hist_s = {hist_r[8:0], din};
                    if (fill_r == 4'd9) begin
                        state_s = ST_SYNC;
                        fill_s  = 4'd0;
                        match_s = 8'd0;
                    end else begin
                        fill_s = fill_r + 4'd1;
                    end
                end
                ST_SYNC: begin
                    hist_s = {hist_r[8:0], din};
                    // An all-zero history predicts zero forever, so a stuck-at-0
                    // line would otherwise look like a perfect match.
                    if ((hist_r == 10'd0) || !hit_s) begin
                        match_s = 8'd0;
                    end else if ((match_r + 8'd1) == LOCK_C) begin
                        state_s = ST_LOCKED;
                        match_s = 8'd0;
                        miss_s  = 8'd0;
                    end else begin
                        match_s = match_r + 8'd1;
                    end
                end
                ST_LOCKED: begin
                    // Feeding back the prediction keeps a corrupted bit out of
                    // the history, so each flip counts exactly once.
                    hist_s = {hist_r[8:0], pred_s};
                    if (!hit_s) begin
                        pulse_s = 1'b1;
                        if (cnt_r != CNT_MAX) begin
                            cnt_s = cnt_r + CNT_ONE;
                        end else begin
                            cnt_s = cnt_r;
                        end
                        if ((miss_r + 8'd1) == LOSS_C) begin
                            state_s = ST_FILL;
                            fill_s  = 4'd0;
                            miss_s  = 8'd0;
                        end else begin
                            miss_s = miss_r + 8'd1;
                        end
                    end else begin
                        miss_s = 8'd0;
                    end
                end
                default: begin
                    state_s = ST_FILL;
                    hist_s  = 10'd0;
                    fill_s  = 4'd0;
                    match_s = 8'd0;
                    miss_s  = 8'd0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
        locked_s = (state_s == ST_LOCKED);
    end

    // State, history, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_FILL;
            hist_r   <= 10'd0;
            fill_r   <= 4'd0;
            match_r  <= 8'd0;
            miss_r   <= 8'd0;
            locked_r <= 1'b0;
            pulse_r  <= 1'b0;
            cnt_r    <= {ERR_W{1'b0}};
        end else begin
            state_r  <= state_s;
            hist_r   <= hist_s;
            fill_r   <= fill_s;
            match_r  <= match_s;
            miss_r   <= miss_s;
            locked_r <= locked_s;
            pulse_r  <= pulse_s;
            cnt_r    <= cnt_s;
        end
    end

endmodule

// File: tb/tb_random_checker.sv
module tb_random_checker;

    logic        clk;
    logic        rst_n;
    logic        bit_en;
    logic        din;
    logic        clear;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic        locked6;
    logic        err_pulse6;
    logic [3:0]  err_count6;

    random_checker #(.LOCK_CNT(20), .LOSS_CNT(4), .ERR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .din(din), .clear(clear),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
    );

    random_checker #(.LOCK_CNT(20), .LOSS_CNT(4), .ERR_W(4)) dut6 (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .din(din), .clear(clear),
        .locked(locked6), .err_pulse(err_pulse6), .err_count(err_count6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic        sel6;
        logic        lk;
        logic        pl;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sbq[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    int          pulses6 = 0;
    logic        due = 1'b0;
    logic        a_lk;
    logic        a_pl;
    logic [15:0] a_cnt;
    logic [9:0]  gh;
    logic [9:0]  seed_v;
    int          gcnt;

    // A response is due one clock after every strobe or clear.
    always @(posedge clk) due <= rst_n & (bit_en | clear);

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (due) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: output presented with no expected entry");
            end else begin
                e     = sbq.pop_front();
                a_lk  = e.sel6 ? locked6 : locked;
                a_pl  = e.sel6 ? err_pulse6 : err_pulse;
                a_cnt = e.sel6 ? {12'd0, err_count6} : err_count;
                if ({a_lk, a_pl, a_cnt} !== {e.lk, e.pl, e.cnt}) begin
                    errors++;
                    $display("FAIL sample%0d: got locked=%0b pulse=%0b cnt=%0d, want locked=%0b pulse=%0b cnt=%0d",
                             e.idx, a_lk, a_pl, a_cnt, e.lk, e.pl, e.cnt);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (err_pulse)  pulses++;
        if (err_pulse6) pulses6++;
    end

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, expv);
        end
    endtask

    task automatic gen(output logic b);
        if (gcnt < 10) b = seed_v[9-gcnt];
        else           b = gh[9] ^ gh[6];
        gh = {gh[8:0], b};
        gcnt++;
    endtask

    task automatic smp(input int n, input logic d, input int gap,
                       input logic lk, input logic pl, input int cnt, input logic s6);
        exp_t x;
        x.idx = n; x.sel6 = s6; x.lk = lk; x.pl = pl; x.cnt = 16'(cnt);
        bit_en = 1'b1;
        din    = d;
        sbq.push_back(x);
        @(posedge clk);
        @(negedge clk);
        bit_en = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic do_clear();
        exp_t x;
        x.idx = -1; x.sel6 = 1'b0; x.lk = 1'b0; x.pl = 1'b0; x.cnt = 16'd0;
        clear = 1'b1;
        sbq.push_back(x);
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_locked", int'(locked), 0);
        chk("rst_count",  int'(err_count), 0);
        rst_n   = 1'b1;
        gh      = 10'd0;
        gcnt    = 0;
        pulses  = 0;
        pulses6 = 0;
    endtask

    initial begin
        logic b;
        logic f;
        int   k;
        rst_n = 1'b0; bit_en = 1'b0; din = 1'b0; clear = 1'b0;
        seed_v = 10'h001; gh = 10'd0; gcnt = 0;
        repeat (3) @(negedge clk);
        chk("reset_locked", int'(locked), 0);
        chk("reset_pulse",  int'(err_pulse), 0);
        chk("reset_count",  int'(err_count), 0);
        chk("reset_count6", int'(err_count6), 0);

        // 1: clean golden stream, strobe every 4 clocks
        do_reset();
        for (int n = 1; n <= 2046; n++) begin
            gen(b);
            smp(n, b, 4, n >= 30, 1'b0, 0, 1'b0);
        end
        chk("t1_pulses", pulses, 0);

        // 2: single flip at sample 100, back-to-back strobes
        do_reset();
        for (int n = 1; n <= 300; n++) begin
            gen(b);
            smp(n, b ^ (n == 100), 1, n >= 30, n == 100, (n >= 100) ? 1 : 0, 1'b0);
        end
        chk("t2_pulses", pulses, 1);

        // 3: burst of four flips drops lock, relock 30 samples later
        do_reset();
        for (int n = 1; n <= 300; n++) begin
            gen(b);
            f = (n >= 200 && n <= 203);
            smp(n, b ^ f, 2, (n >= 30 && n < 203) || n >= 233, f,
                (n < 200) ? 0 : ((n >= 203) ? 4 : n - 199), 1'b0);
        end
        chk("t3_pulses", pulses, 4);

        // 4: stuck-at-0 input never locks
        do_reset();
        for (int n = 1; n <= 500; n++) smp(n, 1'b0, 1, 1'b0, 1'b0, 0, 1'b0);
        chk("t4_pulses", pulses, 0);

        // 5: clear while locked, relock, lose lock, async reset mid-SYNC
        do_reset();
        for (int n = 1; n <= 149; n++) begin
            gen(b);
            smp(n, b ^ (n == 100), 2, n >= 30, n == 100, (n >= 100) ? 1 : 0, 1'b0);
        end
        do_clear();
        for (int n = 150; n <= 205; n++) begin
            gen(b);
            f = (n >= 185 && n <= 188);
            smp(n, b ^ f, 4, n >= 179 && n < 188, f,
                (n < 185) ? 0 : ((n >= 188) ? 4 : n - 184), 1'b0);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_locked", int'(locked), 0);
        chk("async_pulse",  int'(err_pulse), 0);
        chk("async_count",  int'(err_count), 0);

        // 6: 4-bit counter saturates after 20 isolated flips
        do_reset();
        k = 0;
        for (int n = 1; n <= 110; n++) begin
            gen(b);
            f = (n >= 40 && n <= 97 && ((n - 40) % 3) == 0);
            if (f) k++;
            smp(n, b ^ f, 1, n >= 30, f, (k > 15) ? 15 : k, 1'b1);
        end
        chk("t6_pulses", pulses6, 20);
        chk("t6_locked", int'(locked6), 1);

        repeat (2) @(negedge clk);
        chk("sb_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
